// File: rtl/parallel_to_serial.sv
// Purpose : serialises WIDTH-bit parallel words onto a 1-bit stream, MSB first.
// Latency : first bit of a word on dout_serial the cycle after acceptance; words stream back to back.
// Backpressure: one-word holding register; din_ready = !hold_full, drops while a word waits behind the shifter.
//
// Ports:
//   clk            sole clock, rising edge
//   rstn           asynchronous active-low reset
//   din_parallel   word to serialise (WIDTH bits)
//   din_valid      din_parallel valid this cycle
//   din_ready      word accepted this cycle when din_valid is also high (combinational from state)
//   dout_serial    serial data bit (or parity bit), registered
//   dout_valid     dout_serial carries a data bit, registered
//   dout_par_valid dout_serial carries an even-parity bit, registered (tied 0 without P2S_PARITY_EN)
//   busy           shifter or holding register occupied, registered
//
// Optional feature: define P2S_PARITY_EN to append one even-parity cycle after each word.

module parallel_to_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din_parallel,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout_serial,
    output logic             dout_valid,
    output logic             dout_par_valid,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shifter;     // bits still to be sent, aligned to the MSB
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic             hold_full_nxt;
    logic [CNT_W-1:0] bit_cnt;     // index of the data bit currently on dout_serial
`ifdef P2S_PARITY_EN
    logic             par_bit;     // even parity of the word in the shifter
`endif

    logic             accept;
    logic             last_data;
    logic             end_word;
    logic             load_hold;
    logic             load_din;
    logic             load;
    logic             to_hold;
    logic             go_idle;
    logic [WIDTH-1:0] load_word;

    // Ready depends on the holding register only, never on din_valid.
    assign din_ready = !hold_full;

    always_comb begin
        accept    = din_valid && din_ready;
        last_data = (state == SHIFT) && (bit_cnt == LAST_BIT);
`ifdef P2S_PARITY_EN
        // With parity the reload decision moves to the edge that ends the parity cycle.
        end_word  = (state == PAR);
`else
        end_word  = last_data;
`endif
        // A waiting word always wins over a new one; when hold is full din_ready is 0 anyway.
        load_hold = end_word && hold_full;
        load_din  = accept && ((state == IDLE) || (end_word && !hold_full));
        load      = load_hold || load_din;
        to_hold   = accept && !load_din;
        go_idle   = end_word && !load;
        load_word = load_hold ? hold : din_parallel;

        hold_full_nxt = hold_full;
        if (to_hold) begin
            hold_full_nxt = 1'b1;
        end else if (load_hold) begin
            hold_full_nxt = 1'b0;
        end

        state_nxt = state;
        if (load) begin
            state_nxt = SHIFT;
        end else if (go_idle) begin
            state_nxt = IDLE;
`ifdef P2S_PARITY_EN
        end else if (last_data) begin
            state_nxt = PAR;
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            shifter     <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            bit_cnt     <= '0;
            dout_serial <= 1'b0;
            dout_valid  <= 1'b0;
            busy        <= 1'b0;
`ifdef P2S_PARITY_EN
            par_bit        <= 1'b0;
            dout_par_valid <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            hold_full <= hold_full_nxt;
            busy      <= (state_nxt != IDLE) || hold_full_nxt;

            if (to_hold) begin
                hold <= din_parallel;
            end

            if (load) begin
                // MSB goes straight to the output register; the shifter keeps the rest.
                dout_serial <= load_word[WIDTH-1];
                dout_valid  <= 1'b1;
                shifter     <= {load_word[WIDTH-2:0], 1'b0};
                bit_cnt     <= '0;
`ifdef P2S_PARITY_EN
                par_bit        <= ^load_word;
                dout_par_valid <= 1'b0;
`endif
            end else if ((state == SHIFT) && !last_data) begin
                dout_serial <= shifter[WIDTH-1];
                shifter     <= {shifter[WIDTH-2:0], 1'b0};
                bit_cnt     <= bit_cnt + 1'b1;
`ifdef P2S_PARITY_EN
            end else if (last_data) begin
                dout_serial    <= par_bit;
                dout_valid     <= 1'b0;
                dout_par_valid <= 1'b1;
                shifter        <= '0;
                bit_cnt        <= '0;
`endif
            end else if (go_idle) begin
                dout_serial <= 1'b0;
                dout_valid  <= 1'b0;
                shifter     <= '0;
                bit_cnt     <= '0;
`ifdef P2S_PARITY_EN
                dout_par_valid <= 1'b0;
`endif
            end
        end
    end

`ifndef P2S_PARITY_EN
    assign dout_par_valid = 1'b0;
`endif

endmodule

// File: tb/tb_parallel_to_serial.sv
module tb_parallel_to_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic [W-1:0] din_parallel = '0;
    logic         din_valid = 1'b0;
    logic         din_ready, dout_serial, dout_valid, dout_par_valid, busy;

    logic [3:0]   d4 = '0;
    logic         v4 = 1'b0;
    logic         r4, s4, dv4, pv4, b4;

    int cmp_cnt = 0;
    int err_cnt = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    parallel_to_serial #(.WIDTH(W)) u_dut (
        .clk(clk), .rstn(rstn),
        .din_parallel(din_parallel), .din_valid(din_valid), .din_ready(din_ready),
        .dout_serial(dout_serial), .dout_valid(dout_valid),
        .dout_par_valid(dout_par_valid), .busy(busy)
    );

    parallel_to_serial #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rstn(rstn),
        .din_parallel(d4), .din_valid(v4), .din_ready(r4),
        .dout_serial(s4), .dout_valid(dv4),
        .dout_par_valid(pv4), .busy(b4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Every accepted word becomes a run of symbols {first, is_parity, value} appended to a
    // queue; the serial port shows one symbol per cycle, popping the head after each edge.
    // A word is "waiting" (hold occupied) while its first symbol is still queued.
    logic [2:0] q[$];
    bit m_vld = 0, m_par = 0, m_val = 0, m_ready = 1;

    function automatic bit words_waiting_zero();
        foreach (q[i]) if (q[i][2]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q.delete();
            m_vld = 0; m_par = 0; m_val = 0; m_ready = 1;
        end else begin
            if (din_valid && m_ready) begin
                for (int i = W - 1; i >= 0; i--)
                    q.push_back({(i == W - 1), 1'b0, din_parallel[i]});
`ifdef P2S_PARITY_EN
                q.push_back({1'b0, 1'b1, ^din_parallel});
`endif
            end
            if (q.size() > 0) begin
                logic [2:0] s;
                s = q.pop_front();
                m_vld = !s[1]; m_par = s[1]; m_val = s[0];
            end else begin
                m_vld = 0; m_par = 0; m_val = 0;
            end
            m_ready = words_waiting_zero();
        end
    end

    // ---------------- compare + capture ----------------
    logic [63:0] dat_bits, sym_val, sym_kind, c4_bits;
    int          dat_n, sym_n, c4_n;
    bit          rdy_low;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dout_valid", 64'(dout_valid), 64'(m_vld));
            chk("dout_par_valid", 64'(dout_par_valid), 64'(m_par));
            chk("dout_serial", 64'(dout_serial), 64'(m_val));
            chk("din_ready", 64'(din_ready), 64'(m_ready));
            chk("busy", 64'(busy), 64'(m_vld || m_par || !m_ready));
        end
        if (dout_valid) begin
            dat_bits = {dat_bits[62:0], dout_serial};
            dat_n++;
        end
        if (dout_valid || dout_par_valid) begin
            sym_val  = {sym_val[62:0], dout_serial};
            sym_kind = {sym_kind[62:0], dout_valid};
            sym_n++;
        end
        if (!din_ready) rdy_low = 1'b1;
        if (dv4) begin
            c4_bits = {c4_bits[62:0], s4};
            c4_n++;
        end
    end

    task automatic clr_cap();
        dat_bits = '0; sym_val = '0; sym_kind = '0; c4_bits = '0;
        dat_n = 0; sym_n = 0; c4_n = 0; rdy_low = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] w);
        int n;
        n = 0;
        din_parallel = w;
        din_valid = 1'b1;
        while (!din_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            err_cnt++;
            $display("FAIL send_timeout: din_ready stuck at %0b, required 1", din_ready);
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || dout_valid || dout_par_valid) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            err_cnt++;
            $display("FAIL idle_timeout: busy=%0b, required 0", busy);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        clr_cap();
        #1 rstn = 1'b0;
        #2;
        chk("reset_dout_valid", 64'(dout_valid), 64'd0);
        chk("reset_dout_serial", 64'(dout_serial), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_din_ready", 64'(din_ready), 64'd1);
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        // single word
        clr_cap();
        send(8'hF0);
        wait_idle();
        chk("f0_bits", dat_bits, 64'hF0);
        chk("f0_count", 64'(dat_n), 64'd8);
        chk("f0_busy_end", 64'(busy), 64'd0);

        // two words back to back
        clr_cap();
        send(8'hF0);
        send(8'hC3);
        wait_idle();
        chk("f0c3_bits", dat_bits, 64'hF0C3);
        chk("f0c3_count", 64'(dat_n), 64'd16);

        // three words, valid held: hold fills and ready must drop
        clr_cap();
        send(8'hA1);
        send(8'hB2);
        send(8'h3C);
        wait_idle();
        chk("three_bits", dat_bits, 64'hA1B23C);
        chk("three_count", 64'(dat_n), 64'd24);
        chk("three_rdy_low", 64'(rdy_low), 64'd1);

        // reset during bit 3 of 8'hAA with 8'h55 held
        send(8'hAA);
        send(8'h55);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_bit3_val", 64'(dout_serial), 64'd0);
        chk("mid_bit3_vld", 64'(dout_valid), 64'd1);
        chk("mid_hold_full", 64'(din_ready), 64'd0);
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid_outs", {dout_valid, dout_par_valid, dout_serial, busy}, 64'd0);
        chk("rst_mid_ready", 64'(din_ready), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;
        clr_cap();
        repeat (4) @(posedge clk);
        #1;
        chk("no_residual", 64'(sym_n), 64'd0);
        send(8'h0F);
        wait_idle();
        chk("after_rst_bits", dat_bits, 64'h0F);
        chk("after_rst_count", 64'(dat_n), 64'd8);

`ifdef P2S_PARITY_EN
        clr_cap();
        send(8'hC3);
        send(8'h01);
        wait_idle();
        chk("par_count", 64'(sym_n), 64'd18);
        chk("par_vals", sym_val, 64'({8'hC3, 1'b0, 8'h01, 1'b1}));
        chk("par_kinds", sym_kind, 64'({8'hFF, 1'b0, 8'hFF, 1'b0}));
`endif

        // WIDTH=4 instance
        clr_cap();
        d4 = 4'h9;
        v4 = 1'b1;
        chk("w4_ready", 64'(r4), 64'd1);
        @(posedge clk); #1;
        v4 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("w4_bits", c4_bits, 64'h9);
        chk("w4_count", 64'(c4_n), 64'd4);
        chk("w4_busy_end", 64'(b4), 64'd0);

        // randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 300; i++) begin
            send(W'($urandom));
            if ($urandom_range(0, 2) == 0)
                repeat ($urandom_range(1, 12)) @(posedge clk);
            #1;
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
